// File: rtl/fft_peak_pkg.sv
// fft_peak_pkg: shared FSM states and default sizing for the FFT peak detector.
package fft_peak_pkg;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_N_POINTS = 1024;
    localparam int DEF_MAG_W    = 2 * DEF_DATA_W;
    localparam int DEF_BIN_W    = $clog2(DEF_N_POINTS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_FLUSH,
        S_HOLD
    } state_t;
endpackage

// File: rtl/fft_mag_sq.sv
// fft_mag_sq: squares each accepted beat into a register stage and presents re^2 + im^2
// with its bin index; the consumer registers that sum as the second pipeline stage.
module fft_mag_sq #(
    parameter int DATA_W = 16,
    parameter int MAG_W  = 2 * DATA_W,
    parameter int BIN_W  = 10
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_valid,
    input  logic signed [DATA_W-1:0] i_real,
    input  logic signed [DATA_W-1:0] i_imag,
    input  logic [BIN_W-1:0]         i_bin,
    output logic                     o_valid,
    output logic [BIN_W-1:0]         o_bin,
    output logic [MAG_W-1:0]         o_mag
);
    logic signed [MAG_W-1:0] re_x, im_x;
    logic [MAG_W-1:0]        re_sq, im_sq;

    // Full-width operands keep (-2^(DATA_W-1))^2 exact.
    assign re_x  = {{(MAG_W-DATA_W){i_real[DATA_W-1]}}, i_real};
    assign im_x  = {{(MAG_W-DATA_W){i_imag[DATA_W-1]}}, i_imag};
    assign o_mag = re_sq + im_sq;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            o_valid <= 1'b0;
            o_bin   <= '0;
            re_sq   <= '0;
            im_sq   <= '0;
        end else begin
            o_valid <= i_valid;
            if (i_valid) begin
                o_bin <= i_bin;
                re_sq <= $unsigned(re_x * re_x);
                im_sq <= $unsigned(im_x * im_x);
            end
        end
    end
endmodule

// File: rtl/fft_peak_detect.sv
// fft_peak_detect: reports the strongest positive-frequency bin of each FFT frame.
// Option FFT_PEAK_THRESH_EN adds i_thresh; a maximum below it is reported as bin 0, mag 0.
module fft_peak_detect
    import fft_peak_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int N_POINTS = DEF_N_POINTS,
    parameter int MAG_W    = 2 * DATA_W,
    parameter int BIN_W    = $clog2(N_POINTS)
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_sink_valid,
    input  logic                     i_sink_sop,
    input  logic                     i_sink_eop,
    input  logic signed [DATA_W-1:0] i_sink_real,
    input  logic signed [DATA_W-1:0] i_sink_imag,
    input  logic [1:0]               i_sink_error,
    output logic                     o_sink_ready,
`ifdef FFT_PEAK_THRESH_EN
    input  logic [MAG_W-1:0]         i_thresh,
`endif
    output logic                     o_peak_valid,
    input  logic                     i_peak_ready,
    output logic [BIN_W-1:0]         o_peak_bin,
    output logic [MAG_W-1:0]         o_peak_mag,
    output logic                     o_frame_err
);
    state_t           state;
    logic [BIN_W-1:0] cnt, beat_bin, max_bin, mag_bin;
    logic [MAG_W-1:0] max_mag, mag;
    logic             mag_valid, bad, flushed, below;
    logic             accept, sop_acc, in_frame, last_bin, closes, beat_bad, keep_bad, cand;

    assign accept   = i_sink_valid & o_sink_ready;
    assign sop_acc  = accept & i_sink_sop;
    assign in_frame = sop_acc | (accept & (state == S_COLLECT));
    assign beat_bin = i_sink_sop ? '0 : cnt;
    assign last_bin = beat_bin == BIN_W'(N_POINTS - 1);
    assign closes   = i_sink_eop | last_bin;
    assign beat_bad = (|i_sink_error) | (i_sink_eop ^ last_bin);
    assign keep_bad = (state == S_COLLECT) & ~i_sink_sop;
    // Bins below N/2 have a clear MSB; bin 0 is DC.
    assign cand     = mag_valid & ~mag_bin[BIN_W-1] & (|mag_bin);
`ifdef FFT_PEAK_THRESH_EN
    assign below = max_mag < i_thresh;
`else
    assign below = 1'b0;
`endif

    fft_mag_sq #(.DATA_W(DATA_W), .MAG_W(MAG_W), .BIN_W(BIN_W)) u_mag_sq (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_valid   (in_frame),
        .i_real    (i_sink_real),
        .i_imag    (i_sink_imag),
        .i_bin     (beat_bin),
        .o_valid   (mag_valid),
        .o_bin     (mag_bin),
        .o_mag     (mag)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state        <= S_IDLE;
            o_sink_ready <= 1'b0;
            o_peak_valid <= 1'b0;
            o_peak_bin   <= '0;
            o_peak_mag   <= '0;
            o_frame_err  <= 1'b0;
            cnt          <= '0;
            max_mag      <= '0;
            max_bin      <= BIN_W'(1);
            bad          <= 1'b0;
            flushed      <= 1'b0;
        end else begin
            o_frame_err <= 1'b0;
            if (cand && mag > max_mag) begin
                max_mag <= mag;
                max_bin <= mag_bin;
            end
            if (in_frame) cnt <= beat_bin + 1'b1;
            // A new frame wipes whatever the stage-1 beat would have contributed.
            if (sop_acc) begin
                max_mag <= '0;
                max_bin <= BIN_W'(1);
            end
            case (state)
                S_IDLE, S_COLLECT: begin
                    o_sink_ready <= !(in_frame && closes);
                    if (in_frame) begin
                        bad         <= (keep_bad & bad) | beat_bad;
                        o_frame_err <= (state == S_COLLECT) && i_sink_sop;
                        flushed     <= 1'b0;
                        state       <= closes ? S_FLUSH : S_COLLECT;
                    end
                end
                S_FLUSH: begin
                    flushed <= 1'b1;
                    if (flushed) begin
                        if (bad) begin
                            state        <= S_IDLE;
                            o_sink_ready <= 1'b1;
                            o_frame_err  <= 1'b1;
                        end else begin
                            state        <= S_HOLD;
                            o_peak_valid <= 1'b1;
                            o_peak_bin   <= below ? '0 : max_bin;
                            o_peak_mag   <= below ? '0 : max_mag;
                        end
                    end
                end
                S_HOLD: begin
                    if (i_peak_ready) begin
                        state        <= S_IDLE;
                        o_sink_ready <= 1'b1;
                        o_peak_valid <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fft_peak_detect.sv
// tb_fft_peak_detect: directed frames with hand-computed peaks, error and handshake cases.
module tb_fft_peak_detect;
    import fft_peak_pkg::*;

    logic                  i_clk = 1'b0;
    logic                  i_reset_n;
    logic                  i_sink_valid, i_sink_sop, i_sink_eop;
    logic signed [15:0]    i_sink_real, i_sink_imag;
    logic [1:0]            i_sink_error;
    logic                  o_sink_ready, o_peak_valid, i_peak_ready, o_frame_err;
    logic [DEF_BIN_W-1:0]  o_peak_bin;
    logic [DEF_MAG_W-1:0]  o_peak_mag;
`ifdef FFT_PEAK_THRESH_EN
    logic [DEF_MAG_W-1:0]  i_thresh = '0;
`endif

    logic signed [15:0] fr_re [1024];
    logic signed [15:0] fr_im [1024];
    logic [1:0]         fr_err [1024];
    int n_vec = 0;
    int n_err = 0;

    always #5 i_clk = ~i_clk;

    fft_peak_detect dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_sink_valid (i_sink_valid),
        .i_sink_sop   (i_sink_sop),
        .i_sink_eop   (i_sink_eop),
        .i_sink_real  (i_sink_real),
        .i_sink_imag  (i_sink_imag),
        .i_sink_error (i_sink_error),
        .o_sink_ready (o_sink_ready),
`ifdef FFT_PEAK_THRESH_EN
        .i_thresh     (i_thresh),
`endif
        .o_peak_valid (o_peak_valid),
        .i_peak_ready (i_peak_ready),
        .o_peak_bin   (o_peak_bin),
        .o_peak_mag   (o_peak_mag),
        .o_frame_err  (o_frame_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clr();
        for (int i = 0; i < 1024; i++) begin
            fr_re[i]  = 0;
            fr_im[i]  = 0;
            fr_err[i] = 0;
        end
    endtask

    task automatic beat(input bit sop, input bit eop, input logic signed [15:0] re,
                        input logic signed [15:0] im, input logic [1:0] er);
        int t = 0;
        i_sink_valid = 1'b1;
        i_sink_sop   = sop;
        i_sink_eop   = eop;
        i_sink_real  = re;
        i_sink_imag  = im;
        i_sink_error = er;
        while (!o_sink_ready && t < 100) begin
            @(posedge i_clk); #1;
            t++;
        end
        if (!o_sink_ready) chk("sink_ready_timeout", o_sink_ready, 1);
        @(posedge i_clk); #1;
    endtask

    task automatic frame(input int first, input int last, input int eop_at);
        for (int i = first; i <= last; i++) beat(i == 0, i == eop_at, fr_re[i], fr_im[i], fr_err[i]);
        i_sink_valid = 1'b0;
        i_sink_sop   = 1'b0;
        i_sink_eop   = 1'b0;
    endtask

    // Called one tick after the closing beat's edge (E0).
    task automatic expect_peak(input string tag, input int b, input logic [63:0] m);
        chk({tag, ".ready_e0"}, o_sink_ready, 0);
        chk({tag, ".valid_e0"}, o_peak_valid, 0);
        @(posedge i_clk); #1;
        chk({tag, ".valid_e1"}, o_peak_valid, 0);
        @(posedge i_clk); #1;
        chk({tag, ".valid_e2"}, o_peak_valid, 1);
        chk({tag, ".bin"}, o_peak_bin, b);
        chk({tag, ".mag"}, o_peak_mag, m);
        chk({tag, ".err"}, o_frame_err, 0);
        if (i_peak_ready) begin
            @(posedge i_clk); #1;
            chk({tag, ".valid_after_hs"}, o_peak_valid, 0);
            chk({tag, ".ready_after_hs"}, o_sink_ready, 1);
        end
    endtask

    task automatic expect_err(input string tag);
        chk({tag, ".ready_e0"}, o_sink_ready, 0);
        @(posedge i_clk); #1;
        chk({tag, ".err_e1"}, o_frame_err, 0);
        @(posedge i_clk); #1;
        chk({tag, ".err_e2"}, o_frame_err, 1);
        chk({tag, ".valid_e2"}, o_peak_valid, 0);
        chk({tag, ".ready_e2"}, o_sink_ready, 1);
        @(posedge i_clk); #1;
        chk({tag, ".err_e3"}, o_frame_err, 0);
    endtask

    initial begin
        i_reset_n    = 1'b0;
        i_sink_valid = 1'b0;
        i_sink_sop   = 1'b0;
        i_sink_eop   = 1'b0;
        i_sink_real  = 0;
        i_sink_imag  = 0;
        i_sink_error = 0;
        i_peak_ready = 1'b1;
        clr();
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst.ready", o_sink_ready, 0);
        chk("rst.valid", o_peak_valid, 0);
        chk("rst.bin", o_peak_bin, 0);
        chk("rst.mag", o_peak_mag, 0);
        chk("rst.err", o_frame_err, 0);
        i_reset_n = 1'b1;
        @(posedge i_clk); #1;
        chk("rst.ready_after", o_sink_ready, 1);

        fr_re[100] = 1000;
        frame(0, 1023, 1023);
        expect_peak("single", 100, 1000000);

        clr();
        fr_re[10] = -32768; fr_im[10] = -32768;
        fr_re[20] = -32768; fr_im[20] = -32768;
        frame(0, 1023, 1023);
        expect_peak("min_neg", 10, 64'd2147483648);

        clr();
        fr_re[0] = 30000; fr_re[600] = 30000; fr_re[512] = 30000; fr_re[1023] = 30000;
        fr_re[5] = 3; fr_im[5] = 4;
        fr_re[7] = -4; fr_im[7] = 3;
        fr_im[511] = 5;
        frame(0, 1023, 1023);
        expect_peak("range_tie", 5, 25);

        clr();
        fr_re[100] = 1000;
        frame(0, 500, 500);
        expect_err("early_eop");
        clr();
        fr_im[511] = -7;
        frame(0, 1023, 1023);
        expect_peak("after_err", 511, 49);

        clr();
        frame(0, 1023, 1023);
        expect_peak("all_zero", 1, 0);

        frame(0, 1023, -1);
        expect_err("no_eop");

        frame(0, 0, 0);
        expect_err("sop_eop");

        fr_err[3] = 2'b01;
        frame(0, 1023, 1023);
        expect_err("err_code");
        clr();

        fr_re[20] = 100;
        frame(0, 49, -1);
        fr_re[20] = 0;
        fr_re[300] = -5;
        frame(0, 0, -1);
        chk("restart.err", o_frame_err, 1);
        frame(1, 1023, 1023);
        expect_peak("restart", 300, 25);

        clr();
        fr_re[1] = 1; fr_im[1] = 1;
        i_peak_ready = 1'b0;
        frame(0, 1023, 1023);
        expect_peak("hold", 1, 2);
        i_sink_valid = 1'b1;
        i_sink_sop   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge i_clk); #1;
            chk("hold.valid", o_peak_valid, 1);
            chk("hold.bin", o_peak_bin, 1);
            chk("hold.mag", o_peak_mag, 2);
            chk("hold.sink_ready", o_sink_ready, 0);
        end
        i_sink_valid = 1'b0;
        i_sink_sop   = 1'b0;
        i_peak_ready = 1'b1;
        @(posedge i_clk); #1;
        chk("hold.valid_after_hs", o_peak_valid, 0);
        chk("hold.ready_after_hs", o_sink_ready, 1);

        clr();
        fr_re[40] = 77;
        frame(0, 299, -1);
        i_reset_n = 1'b0;
        @(posedge i_clk); #1;
        chk("midrst.err", o_frame_err, 0);
        chk("midrst.valid", o_peak_valid, 0);
        chk("midrst.ready", o_sink_ready, 0);
        i_reset_n = 1'b1;
        @(posedge i_clk); #1;
        chk("midrst.err_after", o_frame_err, 0);
        chk("midrst.ready_after", o_sink_ready, 1);
        clr();
        fr_im[2] = 1;
        frame(0, 1023, 1023);
        expect_peak("post_rst", 2, 1);

`ifdef FFT_PEAK_THRESH_EN
        clr();
        fr_re[5] = 3; fr_im[5] = 4;
        i_thresh = 100;
        frame(0, 1023, 1023);
        expect_peak("thresh_low", 0, 0);
        i_thresh = 25;
        frame(0, 1023, 1023);
        expect_peak("thresh_eq", 5, 25);
        i_thresh = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
